// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage with sizing, big-endian lanes, load extension and access timeout
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] pc,
  input  logic [31:0] insn,
  input  logic [13:0] controls,
  input  logic [31:0] O,
  input  logic [31:0] B,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_insn,
  output logic [13:0] wb_controls,
  output logic [31:0] wb_O,
  output logic [31:0] wb_D,
  output logic        exc_misalign,
  output logic        exc_buserr
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic [7:0]  cnt;
  logic [31:0] h_pc, h_insn, h_o, h_b;
  logic [13:0] h_ctrl;
  logic        in_byte, in_half, in_mis, mem_op, h_byte, h_half, done, tout;
  logic [31:0] sh, ld;
  logic [15:0] ld_h;
  logic        sgn;
  assign in_byte = insn[31:26] == 6'b100000 || insn[31:26] == 6'b100100 || insn[31:26] == 6'b101000;
  assign in_half = insn[31:26] == 6'b100001 || insn[31:26] == 6'b100101 || insn[31:26] == 6'b101001;
  assign in_mis  = controls[12] & (in_half ? O[0] : !in_byte && O[1:0] != 2'b00);
  assign mem_op  = in_valid & controls[12];
  assign h_byte  = h_insn[31:26] == 6'b100000 || h_insn[31:26] == 6'b100100 || h_insn[31:26] == 6'b101000;
  assign h_half  = h_insn[31:26] == 6'b100001 || h_insn[31:26] == 6'b100101 || h_insn[31:26] == 6'b101001;
  assign stall     = state == ACCESS;
  assign mem_req   = state == ACCESS;
  assign mem_we    = mem_req & h_ctrl[9];
  assign mem_addr  = {h_o[31:2], 2'b00};
  assign mem_be    = h_byte ? 4'b1000 >> h_o[1:0] : h_half ? (h_o[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign mem_wdata = h_byte ? {4{h_b[7:0]}} : h_half ? {2{h_b[15:0]}} : h_b;
  assign done = state == ACCESS && mem_ack;
  assign tout = state == ACCESS && !mem_ack && cnt == 8'(TIMEOUT - 1);
  // Byte k sits at bits [31-8k:24-8k], so shift it down by 8*(3-k); opcode bit 2 marks the unsigned loads.
  assign sh   = mem_rdata >> {~h_o[1:0], 3'b000};
  assign ld_h = h_o[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  assign sgn  = ~h_insn[28];
  assign ld   = h_byte ? {{24{sgn & sh[7]}}, sh[7:0]} : h_half ? {{16{sgn & ld_h[15]}}, ld_h} : mem_rdata;
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && mem_op && !in_mis) state_n = ACCESS;
    if (done || tout) state_n = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      {h_pc, h_insn, h_ctrl, h_o, h_b} <= '0;
      {wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D} <= '0;
      exc_misalign <= 1'b0;
      exc_buserr <= 1'b0;
    end else begin
      exc_misalign <= 1'b0;
      exc_buserr <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        wb_valid <= in_valid & !(mem_op & !in_mis);
        if (in_valid && (!controls[12] || in_mis)) begin
          wb_pc <= pc;
          wb_insn <= insn;
          wb_controls <= in_mis ? controls & ~14'h0800 : controls;
          wb_O <= O;
          wb_D <= '0;
          exc_misalign <= in_mis;
        end
        if (mem_op && !in_mis) begin
          h_pc <= pc;
          h_insn <= insn;
          h_ctrl <= controls;
          h_o <= O;
          h_b <= B;
        end
      end else begin
        cnt <= (done || tout) ? 8'd0 : cnt + 8'd1;
        wb_valid <= done | tout;
        if (done || tout) begin
          wb_pc <= h_pc;
          wb_insn <= h_insn;
          wb_controls <= done ? h_ctrl : h_ctrl & ~14'h0800;
          wb_O <= h_o;
          wb_D <= (done && !h_ctrl[9]) ? ld : 32'd0;
          exc_buserr <= tout;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with TIMEOUT=4
module tb_mem_stage;
  logic        clock = 0, reset, in_valid, mem_ack;
  logic [31:0] pc, insn, O, B, mem_rdata;
  logic [13:0] controls;
  logic        stall, mem_req, mem_we, wb_valid, exc_misalign, exc_buserr;
  logic [31:0] mem_addr, mem_wdata, wb_pc, wb_insn, wb_O, wb_D;
  logic [3:0]  mem_be;
  logic [13:0] wb_controls;
  typedef struct packed {
    logic [31:0] pc, insn;
    logic [13:0] ctrl;
    logic [31:0] o, d;
    logic        mis, bus;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;
  localparam logic [13:0] CTRL_ALU = 14'h2800, CTRL_LD = 14'h3800, CTRL_ST = 14'h1200;
  mem_stage #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .pc(pc), .insn(insn),
    .controls(controls), .O(O), .B(B), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_insn(wb_insn), .wb_controls(wb_controls), .wb_O(wb_O), .wb_D(wb_D),
    .exc_misalign(exc_misalign), .exc_buserr(exc_buserr)
  );
  always #5 clock = ~clock;
  task test_reset;
    reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests++;
    if ({stall, mem_req, wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr} !== '0) begin
      fails++;
      $display("FAIL reset: outputs %h required 0", {stall, mem_req, wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr});
    end
    @(posedge clock);
    #1 reset = 0;
  endtask
  task test_passthrough;
    @(posedge clock);
    #1 in_valid = 1; pc = 32'h0000_0400; insn = 32'h0022_1820; controls = CTRL_ALU; O = 32'h5; B = 32'h77;
    q.push_back({pc, insn, controls, O, 32'h0, 2'b00});
    @(negedge clock);
    tests++;
    if ({stall, mem_req} !== 2'b00) begin
      fails++;
      $display("FAIL passthrough_idle: stall/req %b required 00", {stall, mem_req});
    end
    @(posedge clock);
    #1 in_valid = 0;
    @(negedge clock);
    tests++;
    e = q.pop_front();
    if ({wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr, stall, mem_req} !== {1'b1, e, 2'b00}) begin
      fails++;
      $display("FAIL passthrough: got %h required %h", {wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr, stall, mem_req}, {1'b1, e, 2'b00});
    end
  endtask
  task test_back_to_back;
    @(posedge clock);
    #1 in_valid = 1; pc = 32'h500; insn = 32'h0043_2022; controls = CTRL_ALU; O = 32'hAAAA_0001;
    q.push_back({pc, insn, controls, O, 32'h0, 2'b00});
    @(posedge clock);
    #1 pc = 32'h504; insn = 32'h0065_3024; controls = 14'h0; O = 32'h5555_0002;
    q.push_back({pc, insn, controls, O, 32'h0, 2'b00});
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests++;
      e = q.pop_front();
      if ({wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr} !== {1'b1, e}) begin
        fails++;
        $display("FAIL back_to_back[%0d]: got %h required %h", i, {wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr}, {1'b1, e});
      end
      @(posedge clock);
      #1 in_valid = 0;
    end
    @(negedge clock);
    tests++;
    if (wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back_idle: wb_valid %b required 0", wb_valid);
    end
  endtask
  // n = ACCESS cycle on which ack is given; n = 0 never acks and expects a timeout after 4 cycles
  task automatic test_access(input string name, input logic [5:0] op, input logic [31:0] addr, input logic [31:0] bval,
                             input logic [31:0] rdata, input int n, input logic st, input logic [3:0] be,
                             input logic [31:0] wdata, input logic [31:0] d);
    int lim = (n == 0) ? 4 : n;
    logic [13:0] c = st ? CTRL_ST : CTRL_LD;
    @(posedge clock);
    #1 in_valid = 1; pc = $urandom; insn = {op, 26'($urandom)}; controls = c; O = addr; B = bval;
    q.push_back({pc, insn, (n == 0) ? c & ~14'h0800 : c, O, d, 1'b0, n == 0});
    @(posedge clock);
    #1 in_valid = 0; insn = $urandom; O = $urandom; B = $urandom;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clock);
      tests++;
      if ({mem_req, stall, mem_we, mem_addr, mem_be, mem_wdata, wb_valid} !== {2'b11, st, addr[31:2], 2'b00, be, wdata, 1'b0}) begin
        fails++;
        $display("FAIL %s_access[%0d]: got %h required %h", name, i, {mem_req, stall, mem_we, mem_addr, mem_be, mem_wdata, wb_valid}, {2'b11, st, addr[31:2], 2'b00, be, wdata, 1'b0});
      end
      mem_rdata = (i == n) ? rdata : $urandom;
      mem_ack = i == n;
      @(posedge clock);
      #1 mem_ack = 0; mem_rdata = $urandom;
    end
    @(negedge clock);
    tests++;
    e = q.pop_front();
    if ({wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr, mem_req, stall} !== {1'b1, e, 2'b00}) begin
      fails++;
      $display("FAIL %s_wb: got %h required %h", name, {wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr, mem_req, stall}, {1'b1, e, 2'b00});
    end
    @(negedge clock);
    tests++;
    if ({wb_valid, exc_buserr, mem_req} !== 3'b000) begin
      fails++;
      $display("FAIL %s_after: valid/buserr/req %b required 000", name, {wb_valid, exc_buserr, mem_req});
    end
  endtask
  task automatic test_misalign(input string name, input logic [5:0] op, input logic [31:0] addr);
    @(posedge clock);
    #1 in_valid = 1; pc = $urandom; insn = {op, 26'($urandom)}; controls = CTRL_LD; O = addr;
    q.push_back({pc, insn, CTRL_LD & ~14'h0800, O, 32'h0, 2'b10});
    @(negedge clock);
    tests++;
    if ({mem_req, stall} !== 2'b00) begin
      fails++;
      $display("FAIL %s_req: req/stall %b required 00", name, {mem_req, stall});
    end
    @(posedge clock);
    #1 in_valid = 0;
    @(negedge clock);
    tests++;
    e = q.pop_front();
    if ({wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr, mem_req} !== {1'b1, e, 1'b0}) begin
      fails++;
      $display("FAIL %s_wb: got %h required %h", name, {wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr, mem_req}, {1'b1, e, 1'b0});
    end
    @(negedge clock);
    tests++;
    if ({exc_misalign, wb_valid, mem_req} !== 3'b000) begin
      fails++;
      $display("FAIL %s_pulse: misalign/valid/req %b required 000", name, {exc_misalign, wb_valid, mem_req});
    end
  endtask
  task test_reset_mid_access;
    @(posedge clock);
    #1 in_valid = 1; pc = 32'h900; insn = {6'b100011, 26'h12345}; controls = CTRL_LD; O = 32'h4000;
    @(posedge clock);
    #1 in_valid = 0;
    @(negedge clock);
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_req: mem_req %b required 1", mem_req);
    end
    @(posedge clock);
    #1 reset = 1;
    @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    tests++;
    if ({mem_req, stall, wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr} !== '0) begin
      fails++;
      $display("FAIL reset_mid: outputs %h required 0", {mem_req, stall, wb_valid, wb_pc, wb_insn, wb_controls, wb_O, wb_D, exc_misalign, exc_buserr});
    end
  endtask
  initial begin
    {in_valid, mem_ack, pc, insn, O, B, mem_rdata, controls} = '0;
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_access("lb",   6'b100000, 32'h1001, 32'h0, 32'h12F4_5678, 3, 1'b0, 4'b0100, 32'h0, 32'hFFFF_FFF4);
    test_access("lbu",  6'b100100, 32'h1001, 32'h0, 32'h12F4_5678, 3, 1'b0, 4'b0100, 32'h0, 32'h0000_00F4);
    test_access("lb3",  6'b100000, 32'h1003, 32'h0, 32'hFFFF_FF7F, 1, 1'b0, 4'b0001, 32'h0, 32'h0000_007F);
    test_access("lh",   6'b100001, 32'h1002, 32'h0, 32'h1234_8765, 1, 1'b0, 4'b0011, 32'h0, 32'hFFFF_8765);
    test_access("lhu",  6'b100101, 32'h1000, 32'h0, 32'h8765_1234, 2, 1'b0, 4'b1100, 32'h0, 32'h0000_8765);
    test_access("lw",   6'b100011, 32'h1004, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    test_access("sh",   6'b101001, 32'h2002, 32'hABCD_1234, 32'hFFFF_FFFF, 2, 1'b1, 4'b0011, 32'h1234_1234, 32'h0);
    test_access("sw",   6'b101011, 32'h2000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0);
    test_access("sb",   6'b101000, 32'h2001, 32'h0000_00A5, 32'hFFFF_FFFF, 3, 1'b1, 4'b0100, 32'hA5A5_A5A5, 32'h0);
    test_misalign("lw_mis", 6'b100011, 32'h3002);
    test_misalign("lh_mis", 6'b100001, 32'h3001);
    test_access("timeout",  6'b100011, 32'h5000, 32'h0, 32'h0, 0, 1'b0, 4'b1111, 32'h0, 32'h0);
    test_access("ack_last", 6'b100011, 32'h5004, 32'h0, 32'h0BAD_F00D, 4, 1'b0, 4'b1111, 32'h0, 32'h0BAD_F00D);
    test_reset_mid_access();
    test_access("lw_post_reset", 6'b100011, 32'h6008, 32'h0, 32'h1357_9BDF, 2, 1'b0, 4'b1111, 32'h0, 32'h1357_9BDF);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
